// File: rtl/updown_seq_pkg.sv
// -----------------------------------------------------------------------------
// updown_seq_pkg
// Shared definitions for the up/down sequence controller:
//   - state_t : controller FSM states (IDLE, RUN, DONE)
//   - MODE_*  : encodings of the 2-bit sequence mode input
//               (encoding 3 is reserved and behaves as ONESHOT)
// -----------------------------------------------------------------------------
package updown_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_WRAP    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE  = 2'd2;

    // Reserved encoding falls back to ONESHOT.
    function automatic logic is_oneshot(input logic [1:0] m);
        return (m != MODE_WRAP) && (m != MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/updown_step_core.sv
// -----------------------------------------------------------------------------
// updown_step_core
// Counter register of the sequence controller. Loads a value or steps by one
// in the requested direction; arithmetic wraps modulo 2^WIDTH.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (has priority over en)
//   load_val in   [WIDTH] value to load
//   en       in   step by one this cycle
//   dir      in   step direction, 1 = up
//   count    out  [WIDTH] current counter value
// -----------------------------------------------------------------------------
module updown_step_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// -----------------------------------------------------------------------------
// updown_seq_ctrl
// Bounded up/down sequence controller. On start (in IDLE) it latches mode and
// bounds, loads the counter with the start bound and runs in ONESHOT, WRAP or
// BOUNCE mode until the end bound / stop.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   pause     in   (only with UDSEQ_PAUSE_EN) freeze count/dir/state in RUN
//   start     in   begin a sequence (sampled in IDLE only)
//   stop      in   abort; beats start in IDLE and the end-bound action in RUN
//   mode      in   [2] 0 ONESHOT, 1 WRAP, 2 BOUNCE, 3 = ONESHOT
//   lo, hi    in   [WIDTH] unsigned bounds
//   dir_init  in   initial direction, 1 = up (start at lo)
//   count     out  [WIDTH] current counter value
//   dir       out  current direction, 1 = up
//   busy      out  high while in RUN
//   done      out  one-cycle pulse on ONESHOT completion
//   err       out  one-cycle pulse on a start rejected because lo > hi
//
// Build option: define UDSEQ_PAUSE_EN to add the pause input.
// -----------------------------------------------------------------------------
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef UDSEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             dir_init,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             dir_q;   // also holds the latched dir_init for the run
    logic             done_q;
    logic             err_q;

    logic             pause_act;
    logic             start_ok;
    logic             start_bad;
    logic             at_end;
    logic             run_act;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;
    logic             core_dir;

`ifdef UDSEQ_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    assign start_ok  = (state_q == ST_IDLE) && start && !stop && (lo <= hi);
    assign start_bad = (state_q == ST_IDLE) && start && !stop && (lo >  hi);
    assign at_end    = dir_q ? (count == hi_q) : (count == lo_q);
    // RUN cycle in which the counter may move (stop and pause both freeze it)
    assign run_act   = (state_q == ST_RUN) && !stop && !pause_act;

    // Counter control
    always_comb begin
        core_load     = 1'b0;
        core_load_val = count;
        core_en       = 1'b0;
        core_dir      = dir_q;
        if (start_ok) begin
            core_load     = 1'b1;
            core_load_val = dir_init ? lo : hi;
        end else if (run_act) begin
            if (!at_end) begin
                core_en = 1'b1;
            end else if (mode_q == MODE_WRAP) begin
                core_load     = 1'b1;
                core_load_val = dir_q ? lo_q : hi_q;
            end else if (mode_q == MODE_BOUNCE) begin
                // Turn around; with a single-point range the count just holds.
                core_en  = (lo_q != hi_q);
                core_dir = ~dir_q;
            end
        end
    end

    updown_step_core #(
        .WIDTH (WIDTH)
    ) u_step_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .dir      (core_dir),
        .count    (count)
    );

    // Controller FSM with registered pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        mode_q  <= mode;
                        lo_q    <= lo;
                        hi_q    <= hi;
                        dir_q   <= dir_init;
                        state_q <= ST_RUN;
                    end else if (start_bad) begin
                        err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (!pause_act && at_end) begin
                        if (mode_q == MODE_BOUNCE) begin
                            dir_q <= ~dir_q;
                        end else if (is_oneshot(mode_q)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dir  = dir_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
module tb_updown_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dir_init;
    logic [W-1:0] count;
    logic         dir;
    logic         busy;
    logic         done;
    logic         err;
`ifdef UDSEQ_PAUSE_EN
    logic         pause;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    updown_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef UDSEQ_PAUSE_EN
        .pause    (pause),
`endif
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .dir_init (dir_init),
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;
    int bnc_cnt [8] = '{3, 4, 5, 6, 5, 4, 3, 4};
    int bnc_dir [8] = '{1, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 2'd0;
        lo       = '0;
        hi       = '0;
        dir_init = 1'b1;
`ifdef UDSEQ_PAUSE_EN
        pause    = 1'b0;
`endif
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_dir",   32'(dir),   1);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_err",   32'(err),   0);
        tick;
        tick;
        reset = 1'b0;

        // ONESHOT up 2..5
        mode = 2'd0; lo = 4'd2; hi = 4'd5; dir_init = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk("os_cnt_e1",  32'(count), 2);
        chk("os_busy_e1", 32'(busy),  1);
        tick; chk("os_cnt_e2", 32'(count), 3);
        tick; chk("os_cnt_e3", 32'(count), 4);
        tick; chk("os_cnt_e4", 32'(count), 5);
        chk("os_done_e4", 32'(done), 0);
        tick;
        chk("os_done_e5", 32'(done),  1);
        chk("os_busy_e5", 32'(busy),  0);
        chk("os_cnt_e5",  32'(count), 5);
        tick;
        chk("os_done_e6", 32'(done),  0);
        chk("os_cnt_e6",  32'(count), 5);

        // WRAP down 0..15, inputs scrambled mid-run must be ignored
        mode = 2'd1; lo = 4'd0; hi = 4'd15; dir_init = 1'b0; start = 1'b1;
        tick;
        chk("wr_cnt_load", 32'(count), 15);
        chk("wr_dir_load", 32'(dir),   0);
        mode = 2'd0; lo = 4'd3; hi = 4'd9; dir_init = 1'b1;
        exp_cnt = 15;
        for (int i = 0; i < 24; i++) begin
            tick;
            exp_cnt = (exp_cnt == 0) ? 15 : exp_cnt - 1;
            chk("wr_cnt", 32'(count), exp_cnt);
        end
        chk("wr_dir", 32'(dir),  0);
        chk("wr_busy", 32'(busy), 1);
        stop = 1'b1; start = 1'b0;
        tick;
        chk("wr_stop_busy", 32'(busy),  0);
        chk("wr_stop_cnt",  32'(count), 7);
        stop = 1'b0;
        tick;
        chk("wr_idle_cnt", 32'(count), 7);

        // BOUNCE up 3..6
        mode = 2'd2; lo = 4'd3; hi = 4'd6; dir_init = 1'b1; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            start = 1'b0;
            chk("bn_cnt", 32'(count), bnc_cnt[i]);
            chk("bn_dir", 32'(dir),   bnc_dir[i]);
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("bn_stop_busy", 32'(busy), 0);

        // BOUNCE with lo == hi: count holds, dir still toggles
        mode = 2'd2; lo = 4'd8; hi = 4'd8; dir_init = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk("bn1_cnt_e1", 32'(count), 8);
        chk("bn1_dir_e1", 32'(dir),   1);
        tick;
        chk("bn1_cnt_e2", 32'(count), 8);
        chk("bn1_dir_e2", 32'(dir),   0);
        tick;
        chk("bn1_dir_e3", 32'(dir), 1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("bn1_stop_busy", 32'(busy), 0);
        chk("bn1_stop_dir",  32'(dir),  1);

        // Rejected start: lo > hi
        mode = 2'd0; lo = 4'd9; hi = 4'd4; dir_init = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("err_pulse", 32'(err),   1);
        chk("err_busy",  32'(busy),  0);
        chk("err_cnt",   32'(count), 8);
        chk("err_dir",   32'(dir),   1);
        tick;
        chk("err_clear", 32'(err), 0);

        // start together with stop in IDLE: nothing happens
        lo = 4'd2; hi = 4'd5; start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        chk("ss_err",  32'(err),   0);
        chk("ss_busy", 32'(busy),  0);
        chk("ss_cnt",  32'(count), 8);

        // Asynchronous reset mid-RUN at count 5
        mode = 2'd0; lo = 4'd0; hi = 4'd10; dir_init = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("ar_pre_cnt", 32'(count), 5);
        #2 reset = 1'b1;
        #1;
        chk("ar_cnt",  32'(count), 0);
        chk("ar_busy", 32'(busy),  0);
        chk("ar_dir",  32'(dir),   1);
        tick;
        reset = 1'b0;

        // Fresh WRAP up 2..5 after reset
        mode = 2'd1; lo = 4'd2; hi = 4'd5; dir_init = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk("fr_cnt_e1",  32'(count), 2);
        chk("fr_busy_e1", 32'(busy),  1);
        tick;
        chk("fr_cnt_e2", 32'(count), 3);
`ifdef UDSEQ_PAUSE_EN
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ps_hold", 32'(count), 3);
        end
        pause = 1'b0;
        tick; chk("ps_res1", 32'(count), 4);
        tick; chk("ps_res2", 32'(count), 5);
        tick; chk("ps_wrap", 32'(count), 2);
`endif
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("end_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_seq_ctrl.md
UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and bound width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  level-sampled request to begin a sequence; acted on only in IDLE.
REQ-005 SHALL have port stop  input  1  abort request; acted on in RUN and IDLE.
REQ-006 SHALL have port mode  input  2  sequence mode: 0 ONESHOT, 1 WRAP, 2 BOUNCE, 3 reserved (treated as ONESHOT).
REQ-007 SHALL have port lo  input  WIDTH  lower bound, unsigned.
REQ-008 SHALL have port hi  input  WIDTH  upper bound, unsigned.
REQ-009 SHALL have port dir_init  input  1  initial direction: 1 up (start at lo), 0 down (start at hi).
REQ-010 SHALL have port count  output  WIDTH  current counter value.
REQ-011 SHALL have port dir  output  1  current direction, 1 up.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse on ONESHOT completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected start (lo > hi).

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-016 In IDLE, with start=1, stop=0 and lo<=hi: SHALL latch mode, lo, hi and dir_init; load count with lo (dir_init=1) or hi (dir_init=0); load dir from dir_init; enter RUN on the same edge.
REQ-017 In IDLE, with start=1, stop=0 and lo>hi: SHALL pulse err for one cycle, remain in IDLE, and leave count and dir unchanged.
REQ-018 In IDLE, start together with stop: stop SHALL win and start SHALL be ignored (no err).
REQ-019 In RUN, each cycle SHALL compare count to the end bound (hi if dir=1, lo if dir=0); if not equal, count SHALL step by 1 in direction dir.
REQ-020 At the end bound in ONESHOT: SHALL go to DONE and hold count; done=1 for that one cycle.
REQ-021 At the end bound in WRAP: count SHALL reload the start bound (lo if dir=1, hi if dir=0) and dir SHALL stay unchanged.
REQ-022 At the end bound in BOUNCE: dir SHALL invert and count SHALL step by 1 in the new direction; if lo==hi, count SHALL hold and dir SHALL still invert.
REQ-023 In RUN, stop=1 SHALL force IDLE on the next edge with count and dir held; stop has priority over the end-bound action.
REQ-024 In RUN, start SHALL be ignored; lo, hi, mode and dir_init input changes SHALL NOT affect the latched values.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; because stepping is bounded to [lo,hi], count SHALL never leave [lo,hi] during RUN.
REQ-026 busy SHALL equal (state==RUN); done and err SHALL be registered outputs.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, count=0, dir=1, busy=0, done=0, err=0, and clear all latched values, including mid-RUN.

Configuration
REQ-028 With macro UDSEQ_PAUSE_EN defined, SHALL add port pause  input  1; in RUN, pause=1 SHALL hold count, dir and state, while stop still takes priority.
REQ-029 Without UDSEQ_PAUSE_EN, the pause port SHALL be absent and behaviour SHALL be as if pause=0.

Structure
REQ-030 Package updown_seq_pkg SHALL hold the FSM state enum and the mode encodings (MODE_ONESHOT, MODE_WRAP, MODE_BOUNCE).
REQ-031 The count/direction register SHALL be a sub-module updown_step_core (load, load_val, en, dir inputs; count output); the FSM and bound logic SHALL stay in the top module.

Verification (WIDTH=4)
REQ-032 ONESHOT up, lo=2, hi=5, start pulsed one cycle: count 2,3,4,5 on edges 1-4; done=1 after edge 5; busy=0 after edge 5; count holds 5.
REQ-033 WRAP down, lo=0, hi=15: count 15,14,...,0,15,14...; stop when count=7 -> IDLE next edge, count holds 7.
REQ-034 BOUNCE up, lo=3, hi=6: count 3,4,5,6,5,4,3,4; dir falls on the edge where count goes 6->5.
REQ-035 Start with lo=9, hi=4: err one cycle, busy stays 0, count unchanged; start together with stop in IDLE: no err, no RUN.
REQ-036 Assert reset asynchronously mid-RUN at count=5: count=0, busy=0, dir=1 without waiting for a clock edge; after release, a start begins a fresh sequence.
REQ-037 With UDSEQ_PAUSE_EN: pause asserted for 3 cycles in WRAP -> count frozen for those 3 cycles, then resumes from the same value.
